// File: rtl/sbox_sched_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the S-box scheduler.
// The optional input register stage is enabled with SBOX_SCHED_PIPE_EN.
package sbox_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BLK  = 2'd1,
        WORD = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int BLK_BYTES  = 16;
    localparam int WORD_BYTES = 4;
    localparam int IDX_W      = 4;

    localparam logic [IDX_W-1:0] BLK_LAST  = IDX_W'(BLK_BYTES - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORD_BYTES - 1);

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // Multiplication modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 0; k < 7; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/sbox_pprm.sv
// Single AES S-box, forward or inverse, computed algebraically
// (field inversion plus affine map) as purely combinational logic.
module sbox_pprm
    import sbox_sched_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic       encrypt,
    output logic [7:0] byte_out
);

    logic [7:0] w_inv_in;
    logic [7:0] w_inv_out;

    always_comb begin
        // Inverse direction undoes the affine map before inverting.
        w_inv_in  = encrypt ? byte_in
                            : (rotl8(byte_in, 1) ^ rotl8(byte_in, 3) ^ rotl8(byte_in, 6) ^ 8'h05);
        w_inv_out = gf_inv(w_inv_in);
        byte_out  = encrypt ? (w_inv_out ^ rotl8(w_inv_out, 1) ^ rotl8(w_inv_out, 2)
                               ^ rotl8(w_inv_out, 3) ^ rotl8(w_inv_out, 4) ^ 8'h63)
                            : w_inv_out;
    end

endmodule

// File: rtl/sbox_scheduler.sv
// Shares one S-box between 16-byte block jobs and 4-byte SubWord jobs, one byte
// per cycle. Define SBOX_SCHED_PIPE_EN to register the S-box input (adds FIN).
//
// Handshake: a port accepts when valid && ready at a rising edge; ready is high
// only in IDLE, a losing requester must hold valid, and done pulses for one cycle
// once the port's output register holds the complete result.
module sbox_scheduler
    import sbox_sched_pkg::*;
#(
    parameter logic WORD_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         blk_encrypt,
    input  logic [127:0] blk_in,
    output logic [127:0] blk_out,
    output logic         blk_done,
    input  logic         word_valid,
    output logic         word_ready,
    input  logic [31:0]  word_in,
    output logic [31:0]  word_out,
    output logic         word_done,
    output logic [1:0]   dbg_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_enc;
    logic             r_last_word;
    logic             r_blk_done;
    logic             r_word_done;
    logic [127:0]     r_shadow;
    logic [127:0]     r_blk_out;
    logic [31:0]      r_word_out;

    logic             w_grant_blk;
    logic             w_grant_word;
    logic             w_fin_blk;
    logic             w_fin_word;
    logic             w_busy;
    logic [7:0]       w_byte_sel;
    logic [7:0]       w_sbox_in;
    logic [7:0]       w_sbox_out;
    logic             w_wr_blk;
    logic             w_wr_word;
    logic [IDX_W-1:0] w_wr_idx;

`ifdef SBOX_SCHED_PIPE_EN
    logic [7:0]       r_pipe_byte;
    logic             r_wr_en;
    logic             r_wr_word;
    logic [IDX_W-1:0] r_wr_idx;
`endif

    // Byte 0 sits in the top bits; a word job is parked in r_shadow[127:96].
    assign w_byte_sel = r_shadow[{~r_idx, 3'b000} +: 8];

`ifdef SBOX_SCHED_PIPE_EN
    assign w_sbox_in = r_pipe_byte;
    assign w_wr_blk  = r_wr_en & ~r_wr_word;
    assign w_wr_word = r_wr_en & r_wr_word;
    assign w_wr_idx  = r_wr_idx;
`else
    assign w_sbox_in = w_byte_sel;
    assign w_wr_blk  = (r_state == BLK);
    assign w_wr_word = (r_state == WORD);
    assign w_wr_idx  = r_idx;
`endif

    sbox_pprm u_sbox (
        .byte_in  (w_sbox_in),
        .encrypt  (r_enc),
        .byte_out (w_sbox_out)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_blk  = 1'b0;
        w_grant_word = 1'b0;
        w_fin_blk    = 1'b0;
        w_fin_word   = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (blk_valid && word_valid) begin
                    if (r_last_word || !WORD_FIRST) w_grant_blk  = 1'b1;
                    else                            w_grant_word = 1'b1;
                end else begin
                    w_grant_blk  = blk_valid;
                    w_grant_word = word_valid;
                end
                if (w_grant_blk)       w_state_nxt = BLK;
                else if (w_grant_word) w_state_nxt = WORD;
            end
            BLK: begin
                w_busy = 1'b1;
                if (r_idx == BLK_LAST) begin
`ifdef SBOX_SCHED_PIPE_EN
                    w_state_nxt = FIN;
`else
                    w_fin_blk   = 1'b1;
                    w_state_nxt = IDLE;
`endif
                end
            end
            WORD: begin
                w_busy = 1'b1;
                if (r_idx == WORD_LAST) begin
`ifdef SBOX_SCHED_PIPE_EN
                    w_state_nxt = FIN;
`else
                    w_fin_word  = 1'b1;
                    w_state_nxt = IDLE;
`endif
                end
            end
`ifdef SBOX_SCHED_PIPE_EN
            FIN: begin
                w_fin_blk   = ~r_wr_word;
                w_fin_word  = r_wr_word;
                w_state_nxt = IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_enc       <= 1'b0;
            r_last_word <= 1'b0;
            r_blk_done  <= 1'b0;
            r_word_done <= 1'b0;
            r_shadow    <= '0;
            r_blk_out   <= '0;
            r_word_out  <= '0;
`ifdef SBOX_SCHED_PIPE_EN
            r_pipe_byte <= '0;
            r_wr_en     <= 1'b0;
            r_wr_word   <= 1'b0;
            r_wr_idx    <= '0;
`endif
        end else begin
            r_blk_done  <= w_fin_blk;
            r_word_done <= w_fin_word;
            if (w_fin_blk)  r_last_word <= 1'b0;
            if (w_fin_word) r_last_word <= 1'b1;

            if (w_grant_blk) begin
                r_shadow <= blk_in;
                r_enc    <= blk_encrypt;
                r_idx    <= '0;
            end else if (w_grant_word) begin
                r_shadow <= {word_in, 96'd0};
                r_enc    <= 1'b1;
                r_idx    <= '0;
            end else if (w_busy) begin
                r_idx <= r_idx + 4'd1;
            end

`ifdef SBOX_SCHED_PIPE_EN
            // The write lags the index by one cycle; FIN retires the last byte.
            r_wr_en   <= w_busy;
            r_wr_idx  <= r_idx;
            r_wr_word <= (r_state == WORD);
            if (w_busy) r_pipe_byte <= w_byte_sel;
`endif

            if (w_wr_blk)  r_blk_out[{~w_wr_idx, 3'b000} +: 8]       <= w_sbox_out;
            if (w_wr_word) r_word_out[{~w_wr_idx[1:0], 3'b000} +: 8] <= w_sbox_out;
        end
    end

    assign blk_ready  = (r_state == IDLE);
    assign word_ready = (r_state == IDLE);
    assign blk_out    = r_blk_out;
    assign word_out   = r_word_out;
    assign blk_done   = r_blk_done;
    assign word_done  = r_word_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Self-checking bench for sbox_scheduler: job-level reference model with
// byte-progress tracking, directed cases and a randomized job mix.
module tb_sbox_scheduler;

`ifdef SBOX_SCHED_PIPE_EN
    localparam int L_BLK  = 17;
    localparam int L_WORD = 5;
    localparam int PIPE   = 1;
`else
    localparam int L_BLK  = 16;
    localparam int L_WORD = 4;
    localparam int PIPE   = 0;
`endif
    localparam logic WORD_FIRST_TB = 1'b1;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset_n;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_encrypt;
    logic [127:0] blk_in;
    logic [127:0] blk_out;
    logic         blk_done;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word_in;
    logic [31:0]  word_out;
    logic         word_done;
    logic [1:0]   dbg_state;

    initial forever #5 clk = ~clk;

    sbox_scheduler #(.WORD_FIRST(WORD_FIRST_TB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_encrypt (blk_encrypt),
        .blk_in      (blk_in),
        .blk_out     (blk_out),
        .blk_done    (blk_done),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_in     (word_in),
        .word_out    (word_out),
        .word_done   (word_done),
        .dbg_state   (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    bit rand_mode = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- S-box tables (log/antilog generation) ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] d, input logic enc, input int nb);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = enc ? sb[d[8*i +: 8]] : isb[d[8*i +: 8]];
        return r;
    endfunction

    // ---------------- reference model ----------------
    int           m_job      = 0;   // 0 none, 1 block, 2 word
    int           m_left     = 0;
    logic         m_last_word = 1'b0;
    logic         m_blk_done  = 1'b0;
    logic         m_word_done = 1'b0;
    logic         m_blk_acc   = 1'b0;
    logic         m_word_acc  = 1'b0;
    logic [127:0] m_blk_out   = '0;
    logic [127:0] m_blk_old   = '0;
    logic [31:0]  m_word_out  = '0;
    logic [31:0]  m_word_old  = '0;
    logic [127:0] exp_blk_q[$];
    logic [31:0]  exp_word_q[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_job = 0; m_left = 0; m_last_word = 1'b0;
            m_blk_done = 1'b0; m_word_done = 1'b0; m_blk_acc = 1'b0; m_word_acc = 1'b0;
            m_blk_out = '0; m_blk_old = '0; m_word_out = '0; m_word_old = '0;
            exp_blk_q.delete();
            exp_word_q.delete();
        end else begin
            m_blk_done = 1'b0; m_word_done = 1'b0; m_blk_acc = 1'b0; m_word_acc = 1'b0;
            if (m_job != 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_job == 1) begin m_blk_done = 1'b1;  m_last_word = 1'b0; end
                    else            begin m_word_done = 1'b1; m_last_word = 1'b1; end
                    m_job = 0;
                end
            end else if (blk_valid || word_valid) begin
                if (blk_valid && (!word_valid || m_last_word || !WORD_FIRST_TB)) begin
                    m_job = 1; m_left = L_BLK; m_blk_acc = 1'b1;
                    m_blk_old = m_blk_out;
                    m_blk_out = sub_bytes(blk_in, blk_encrypt, 16);
                    exp_blk_q.push_back(m_blk_out);
                end else begin
                    m_job = 2; m_left = L_WORD; m_word_acc = 1'b1;
                    m_word_old = m_word_out;
                    m_word_out = 32'(sub_bytes({96'd0, word_in}, 1'b1, 4));
                    exp_word_q.push_back(m_word_out);
                end
            end
        end
    end

    // Visible output: bytes already written come from the new result, the rest hold.
    function automatic logic [127:0] vis_blk();
        int n;
        logic [127:0] v;
        if (m_job != 1) return m_blk_out;
        n = L_BLK - m_left - PIPE;
        if (n < 0) n = 0;
        if (n > 16) n = 16;
        v = m_blk_old;
        for (int i = 0; i < n; i++) v[8*(15-i) +: 8] = m_blk_out[8*(15-i) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] vis_word();
        int n;
        logic [31:0] v;
        if (m_job != 2) return m_word_out;
        n = L_WORD - m_left - PIPE;
        if (n < 0) n = 0;
        if (n > 4) n = 4;
        v = m_word_old;
        for (int i = 0; i < n; i++) v[8*(3-i) +: 8] = m_word_out[8*(3-i) +: 8];
        return v;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        logic [127:0] ev;
        forever begin
            @(negedge clk);
            chk("blk_ready",  blk_ready,  m_job == 0);
            chk("word_ready", word_ready, m_job == 0);
            chk("blk_done",   blk_done,   m_blk_done);
            chk("word_done",  word_done,  m_word_done);
            chk("blk_out",    blk_out,    vis_blk());
            chk("word_out",   word_out,   vis_word());
            if (blk_done) begin
                ev = (exp_blk_q.size() > 0) ? exp_blk_q.pop_front() : 'x;
                chk("blk_sb", blk_out, ev);
            end
            if (word_done) begin
                ev = (exp_word_q.size() > 0) ? {96'd0, exp_word_q.pop_front()} : 'x;
                chk("word_sb", word_out, ev);
            end
        end
    end

    // ---------------- drivers ----------------
    logic [127:0] blk_data_q[$];
    logic         blk_enc_q[$];
    logic [31:0]  word_data_q[$];

    task automatic push_blk(input logic [127:0] d, input logic enc);
        blk_data_q.push_back(d);
        blk_enc_q.push_back(enc);
    endtask

    task automatic push_word(input logic [31:0] d);
        word_data_q.push_back(d);
    endtask

    initial begin
        blk_valid = 1'b0; blk_in = '0; blk_encrypt = 1'b0;
        forever begin
            @(negedge clk);
            if (m_blk_acc) begin
                blk_valid   = 1'b0;
                blk_in      = {$urandom(), $urandom(), $urandom(), $urandom()};
                blk_encrypt = 1'($urandom_range(0, 1));
            end
            if (!blk_valid && reset_n && blk_data_q.size() > 0 &&
                (!rand_mode || $urandom_range(0, 2) != 0)) begin
                blk_in      = blk_data_q.pop_front();
                blk_encrypt = blk_enc_q.pop_front();
                blk_valid   = 1'b1;
            end
        end
    end

    initial begin
        word_valid = 1'b0; word_in = '0;
        forever begin
            @(negedge clk);
            if (m_word_acc) begin
                word_valid = 1'b0;
                word_in    = $urandom();
            end
            if (!word_valid && reset_n && word_data_q.size() > 0 &&
                (!rand_mode || $urandom_range(0, 2) != 0)) begin
                word_in    = word_data_q.pop_front();
                word_valid = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (i < budget && !(m_job == 0 && !blk_valid && !word_valid &&
                               blk_data_q.size() == 0 && word_data_q.size() == 0)) begin
            @(negedge clk);
            i++;
        end
        chk("idle_timeout", i < budget, 1'b1);
    endtask

    task automatic wait_done(output int which, output int n);
        which = 0;
        n = 0;
        while (which == 0 && n < 80) begin
            @(negedge clk);
            n++;
            if (blk_done)       which = 1;
            else if (word_done) which = 2;
        end
    endtask

    task automatic wait_job(input int job);
        int i;
        i = 0;
        while (i < 80 && m_job != job) begin
            @(negedge clk);
            i++;
        end
        chk("job_start_timeout", i < 80, 1'b1);
    endtask

    task automatic measure_latency(input bit is_blk, output int n, output bit any_ready);
        n = 0;
        any_ready = 1'b0;
        while (!(is_blk ? blk_done : word_done) && n < 40) begin
            @(negedge clk);
            n++;
            if (!(is_blk ? blk_done : word_done) && (is_blk ? blk_ready : word_ready)) any_ready = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int which, n;
        bit any_ready;
        reset_n = 1'b0;
        build_tables();
        chk("tbl_sb_00", sb[8'h00], 8'h63);
        chk("tbl_sb_01", sb[8'h01], 8'h7C);
        chk("tbl_sb_02", sb[8'h02], 8'h77);
        chk("tbl_sb_03", sb[8'h03], 8'h7B);
        chk("tbl_sb_53", sb[8'h53], 8'hED);
        chk("tbl_isb_63", isb[8'h63], 8'h00);
        chk("tbl_isb_ed", isb[8'hED], 8'h53);

        repeat (3) @(negedge clk);
        chk("rst_blk_out", blk_out, 128'd0);
        chk("rst_ready", {blk_ready, word_ready}, 2'b11);
        reset_n = 1'b1;

        // block of zeros: latency and ready low throughout
        push_blk(128'd0, 1'b1);
        wait_job(1);
        measure_latency(1'b1, n, any_ready);
        chk("blk_latency", n, L_BLK);
        chk("blk_ready_low", any_ready, 1'b0);
        wait_idle(100);
        chk("blk_zero_out", blk_out, {16{8'h63}});

        push_word(32'h00010203);
        wait_job(2);
        measure_latency(1'b0, n, any_ready);
        chk("word_latency", n, L_WORD);
        wait_idle(100);
        chk("word_out_lit", word_out, 32'h637C777B);

        // back-to-back words: second accepted in the done cycle
        push_word(32'h00010203);
        push_word(32'h53535353);
        wait_done(which, n);
        chk("b2b_first", which, 2);
        chk("b2b_first_out", word_out, 32'h637C777B);
        wait_done(which, n);
        chk("b2b_second", which, 2);
        chk("b2b_gap", n, L_WORD + 1);
        chk("b2b_second_out", word_out, 32'hEDEDEDED);

        push_blk({16{8'h63}}, 1'b0);
        push_blk({16{8'hED}}, 1'b0);
        push_blk({8'h00, {15{8'h53}}}, 1'b1);
        wait_done(which, n);
        chk("dec_63", blk_out, 128'd0);
        wait_done(which, n);
        chk("dec_ed", blk_out, {16{8'h53}});
        wait_done(which, n);
        chk("byte_order", blk_out, {8'h63, {15{8'hED}}});
        wait_idle(100);

        // arbitration: last job was a block, so the word port wins the tie
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
        push_word($urandom());
        wait_done(which, n);
        chk("arb_word_first", which, 2);
        push_word($urandom());
        wait_done(which, n);
        chk("arb_blk_then", which, 1);
        wait_job(2);
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
        push_word($urandom());
        wait_done(which, n);
        chk("arb_word_running", which, 2);
        wait_done(which, n);
        chk("arb_fair_blk", which, 1);
        wait_idle(100);

        // async reset in the middle of a block
        push_blk({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
        wait_job(1);
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_blk_out", blk_out, 128'd0);
        chk("abort_word_out", word_out, 32'd0);
        chk("abort_done", {blk_done, word_done}, 2'b00);
        chk("abort_ready", {blk_ready, word_ready}, 2'b11);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        push_blk(128'd0, 1'b1);
        push_word(32'h00010203);
        wait_done(which, n);
        chk("rst_fair_cleared", which, 2);
        wait_done(which, n);
        chk("post_rst_blk", blk_out, {16{8'h63}});
        wait_idle(100);

        // randomized mix
        rand_mode = 1'b1;
        for (int j = 0; j < 24; j++) begin
            push_blk({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            push_word($urandom());
        end
        wait_idle(4000);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sbox_scheduler.md
# sbox_scheduler

Sequencer and arbiter sharing one `sbox_pprm` instance between the round datapath (16-byte SubBytes/InvSubBytes) and the key expansion (4-byte SubWord). It serialises each job one byte per cycle through the single S-box and returns the full substituted block or word with a done pulse. It sits between the AES round controller / key-schedule logic and the S-box, replacing per-lane S-box instances in area-optimised builds.

## Interface
- `WORD_FIRST`, default 1: tie-break winner when both ports request from IDLE and fairness does not apply (1 = word port, 0 = block port).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `blk_valid` in 1: block job request.
- `blk_ready` out 1: block port can accept.
- `blk_encrypt` in 1: 1 = forward S-box, 0 = inverse; sampled at accept.
- `blk_in` in 128: state block; byte 0 = [127:120], byte 15 = [7:0].
- `blk_out` out 128: substituted block.
- `blk_done` out 1: one-cycle pulse, `blk_out` complete.
- `word_valid` in 1: SubWord request; always forward S-box.
- `word_ready` out 1: word port can accept.
- `word_in` in 32: word; byte 0 = [31:24].
- `word_out` out 32: substituted word.
- `word_done` out 1: one-cycle pulse, `word_out` complete.

## Operation
- FSM states: IDLE, BLK, WORD, with FIN under `SBOX_SCHED_PIPE_EN` only. Reset state is IDLE.
- `blk_ready` = `word_ready` = (state == IDLE). Both read 1 while in reset. Accept = valid && ready at a rising edge.
- Accepting a job captures the input into a shadow register, captures the encrypt bit (word forces 1), clears the byte index to 0, and moves to BLK or WORD.
- Each busy cycle presents shadow byte[index] to the S-box. The result is written into byte[index] of the port's output register at the next edge, and the index increments.
- After the last byte (index 15 for a block, 3 for a word) is written: pulse the port's done and return to IDLE.
- Arbitration in IDLE: a single valid wins. Both valid: if the last completed job was a word, the block wins (fairness). Otherwise the `WORD_FIRST` winner takes the grant. The loser's valid must stay high; it is served on the next IDLE.
- No preemption: a request arriving mid-job waits. Inputs other than the accepted valid are don't-care during a job.
- Output registers change only while their own port's job runs. They hold their value after done until the next job on that port.
- A new accept is possible in the cycle where done is high (state is already IDLE).
- Asynchronous reset mid-job aborts the job: outputs go to zero, no done is issued, and the fairness flag is cleared.

## Timing
- Reset values: `blk_out` = 0, `word_out` = 0, `blk_done` = 0, `word_done` = 0, `blk_ready` = `word_ready` = 1, fairness flag = 0.
- Without the macro: accept edge E0, done high during the cycle after edge E16 (block) or E4 (word). Latency is 16/4 cycles. Back-to-back throughput is one job per 17/5 cycles.
- With the macro: one extra cycle, so latency is 17/5.
- The S-box path is combinational, so per-cycle timing is shadow mux → S-box → output register.

## Configuration
- `SBOX_SCHED_PIPE_EN` defined: a register is inserted between the byte mux and the S-box input. Writes trail the index by one cycle, the FIN state drains the final byte, and latency grows by one cycle as above.
- `SBOX_SCHED_PIPE_EN` undefined: no input register and no FIN state.
- Byte ordering, arbitration and reset behaviour are identical in both builds.

## Structure
- `sbox_sched_pkg` holds:
  - the state enum (IDLE/BLK/WORD/FIN);
  - `BLK_BYTES` = 16 and `WORD_BYTES` = 4;
  - the index width (4 bits);
  - the last-index constants.
- One sub-module instance: the existing `sbox_pprm`, driven with `byte_in` = selected byte and `encrypt` = captured encrypt bit. Its `byte_out` is routed to the output registers.

## Test plan
- Reset, then block `blk_in` = all 0x00 with `blk_encrypt` = 1 → `blk_out` = all 0x63, `blk_done` exactly 16 cycles after accept (17 with macro), `blk_ready` low throughout.
- Word `word_in` = 0x00010203 → `word_out` = 0x637C777B, `word_done` 4 cycles after accept.
- Block all 0x63 then all 0xED with `blk_encrypt` = 0 → all 0x00, then all 0x53. Byte order check: `blk_in` = 0x00 followed by fifteen 0x53 bytes, encrypt → 0x63 followed by fifteen 0xED bytes.
- Arbitration with `WORD_FIRST` = 1:
  - both valid in IDLE → word served first, then block (fairness);
  - word reasserted during the block → waits;
  - word valid during a word job with block pending → block wins next.
- Reset asserted at byte 7 of a block → outputs 0 immediately, no `blk_done`, and the next block job completes correctly.
- Accept a new word in the same cycle `word_done` is high → second result correct, first `word_out` held until the second job's first write.
